// File: rtl/uart_program_loader.sv
// UART (8N1) program loader: receives LEN, N instruction bytes and CSUM, streams the bytes
// into instruction memory and holds the core until a frame with a good checksum lands.
module uart_program_loader #(
    parameter int CLK_HZ       = 16000000,
    parameter int BAUD         = 115200,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_CLKS = 160000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              hold,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W:0]   prog_len,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);
    localparam int CPB   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(CPB);
    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam int PL_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

    logic             rx_meta, rx_sync, rx_last;
    bit_state_t       bstate;
    logic [CNT_W-1:0] bcnt;
    logic [2:0]       bidx;
    logic [7:0]       shreg;

    state_t           state;
    logic [7:0]       len;
    logic [7:0]       idx;
    logic [7:0]       sum;
    logic [TMO_W-1:0] tmo;

    logic eng_idle, fall, start_ok, stop_tick, byte_valid, frame_err, in_frame;

    assign eng_idle   = (bstate == B_IDLE);
    assign fall       = eng_idle && rx_last && !rx_sync;
    // A frame only begins once the start bit is confirmed low at mid-bit, so glitches never wake the FSM.
    assign start_ok   = (bstate == B_START) && (bcnt == HALF_LAST) && !rx_sync;
    assign stop_tick  = (bstate == B_STOP) && (bcnt == BIT_LAST);
    assign byte_valid = stop_tick && rx_sync;
    assign frame_err  = stop_tick && !rx_sync;
    assign in_frame   = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_last <= 1'b1;
            bstate  <= B_IDLE;
            bcnt    <= '0;
            bidx    <= '0;
            shreg   <= '0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_last <= rx_sync;
            case (bstate)
                B_IDLE: begin
                    if (fall) begin
                        bstate <= B_START;
                        bcnt   <= '0;
                    end
                end
                B_START: begin
                    if (bcnt == HALF_LAST) begin
                        bcnt   <= '0;
                        bidx   <= '0;
                        bstate <= rx_sync ? B_IDLE : B_DATA;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                B_DATA: begin
                    if (bcnt == BIT_LAST) begin
                        bcnt  <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        bidx  <= bidx + 1'b1;
                        if (bidx == 3'd7) bstate <= B_STOP;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                B_STOP: begin
                    if (bcnt == BIT_LAST) begin
                        bcnt   <= '0;
                        bstate <= B_IDLE;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            hold     <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            prog_len <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
            len      <= '0;
            idx      <= '0;
            sum      <= '0;
            tmo      <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;

            if (!in_frame || start_ok) tmo <= '0;
            else if (eng_idle)         tmo <= tmo + 1'b1;

            if (in_frame && frame_err) begin
                state    <= S_ERR;
                err      <= 1'b1;
                err_code <= 2'd1;
            end else if (in_frame && eng_idle && tmo == TMO_LAST) begin
                state    <= S_ERR;
                err      <= 1'b1;
                err_code <= 2'd3;
            end else begin
                case (state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (start_ok) begin
                            state <= S_LEN;
                            hold  <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_LEN: begin
                        if (byte_valid) begin
                            if (shreg == 8'd0) begin
                                state    <= S_ERR;
                                err      <= 1'b1;
                                err_code <= 2'd0;
                            end else begin
                                len   <= shreg;
                                idx   <= '0;
                                sum   <= '0;
                                state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (byte_valid) begin
                            wr_en   <= 1'b1;
                            wr_addr <= ADDR_W'(idx);
                            wr_data <= shreg;
                            idx     <= idx + 8'd1;
                            sum     <= sum + shreg;
                            if (idx == len - 8'd1) state <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        if (byte_valid) begin
                            if (8'(sum + shreg) == 8'd0) begin
                                state    <= S_DONE;
                                done     <= 1'b1;
                                prog_len <= PL_W'(len);
                                hold     <= 1'b0;
                            end else begin
                                state    <= S_ERR;
                                err      <= 1'b1;
                                err_code <= 2'd2;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: directed frame table, hand-written corner sequences and
// randomized frames scored against a frame-level reference model.
module tb_uart_program_loader;
    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       hold, wr_en, done, err;
    logic [7:0] wr_addr, wr_data;
    logic [8:0] prog_len;
    logic [1:0] err_code;

    uart_program_loader #(
        .CLK_HZ(800), .BAUD(100), .ADDR_W(8), .TIMEOUT_CLKS(200)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .hold(hold), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .prog_len(prog_len),
        .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int          n_pass = 0, n_total = 0;
    int          cyc = 0, wr_total = 0, done_n = 0, err_n = 0, wr_cyc = 0, err_cyc = 0;
    logic [15:0] wr_log [1024];
    logic [7:0]  fb [$];
    int          bad = -1;
    int          exp_pl = 0, exp_code = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (wr_en) begin
                if (wr_total < 1024) wr_log[wr_total] = {wr_addr, wr_data};
                wr_total++;
                wr_cyc = cyc;
            end
            if (done) done_n++;
            if (err) begin
                err_n++;
                err_cyc = cyc;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    // Frame-level reference: walk the byte list by the protocol rules.
    // ek: 0 = done, 1 = error; ec: error code; enw: writes issued before the outcome.
    function automatic void model(output int ek, output int ec, output int enw);
        int         flen;
        logic [7:0] s;
        ek = 1; ec = 3; enw = 0; s = 8'd0;
        if (fb.size() == 0) return;
        if (bad == 0) begin ec = 1; return; end
        flen = int'(fb[0]);
        if (flen == 0) begin ec = 0; return; end
        for (int i = 1; i <= flen; i++) begin
            if (i >= fb.size()) return;
            if (i == bad) begin ec = 1; return; end
            enw++;
            s = s + fb[i];
        end
        if (fb.size() <= flen + 1) return;
        if (bad == flen + 1) begin ec = 1; return; end
        s = s + fb[flen + 1];
        if (s == 8'd0) begin ek = 0; ec = 0; end
        else ec = 2;
    endfunction

    task automatic run_frame(input int ek, input int ec, input int enw);
        int b_wr, b_done, b_err, k, nw, kind, d;
        b_wr = wr_total; b_done = done_n; b_err = err_n;
        for (int i = 0; i < fb.size(); i++) begin
            send_byte(fb[i], (i != bad));
            if (i == 0) chk("hold_busy", 32'(hold), 1);
            if (i == bad) break;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        k = 0;
        while (done_n == b_done && err_n == b_err && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("outcome_seen", 32'(done_n != b_done || err_n != b_err), 1);
        kind = (done_n != b_done) ? 0 : 1;
        chk("outcome_kind", kind, ek);
        if (ek == 1) begin
            chk("err_code", 32'(err_code), ec);
            exp_code = ec;
        end
        if (ek == 1 && ec == 3 && enw > 0) begin
            d = err_cyc - wr_cyc;
            chk("tmo_latency", 32'(d >= 196 && d <= 204), 1);
        end
        nw = wr_total - b_wr;
        chk("wr_count", nw, enw);
        for (int j = 0; j < nw && j < enw; j++)
            if (b_wr + j < 1024)
                chk("wr_addr_data", 32'(wr_log[b_wr + j]), 32'({8'(j), fb[j + 1]}));
        if (ek == 0) exp_pl = int'(fb[0]);
        repeat (12) @(negedge clk);
        chk("single_pulse", (done_n - b_done) + (err_n - b_err), 1);
        chk("prog_len", 32'(prog_len), exp_pl);
        chk("hold_after", 32'(hold), (ek == 0) ? 0 : 1);
        chk("err_code_held", 32'(err_code), exp_code);
    endtask

    typedef struct {
        int              n;
        logic [0:7][7:0] b;
        int              bad;
        int              ek;
        int              ec;
        int              enw;
    } vec_t;

    vec_t tv [8];

    initial begin
        int         b_wr, b_done, b_err, hold0, ek, ec, enw, flen, r, keep;
        logic [7:0] s, v;

        tv[0] = '{5, {8'h03, 8'h00, 8'h02, 8'h02, 8'hFC, 8'h00, 8'h00, 8'h00}, -1, 0, 0, 3};
        tv[1] = '{5, {8'h03, 8'h00, 8'h02, 8'h02, 8'hFB, 8'h00, 8'h00, 8'h00}, -1, 1, 2, 3};
        tv[2] = '{4, {8'h02, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 1, 2, 2};
        tv[3] = '{1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 1, 0, 0};
        tv[4] = '{3, {8'h03, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00},  2, 1, 1, 1};
        tv[5] = '{2, {8'h04, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 1, 3, 1};
        tv[6] = '{3, {8'h01, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 0, 0, 1};
        tv[7] = '{1, {8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},  0, 1, 1, 0};

        repeat (3) @(negedge clk);
        chk("rst_hold", 32'(hold), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_prog_len", 32'(prog_len), 0);
        chk("rst_done_err", 32'({done, err}), 0);
        chk("rst_err_code", 32'(err_code), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            fb.delete();
            for (int j = 0; j < tv[i].n; j++) fb.push_back(tv[i].b[j]);
            bad = tv[i].bad;
            run_frame(tv[i].ek, tv[i].ec, tv[i].enw);
        end

        // Short low glitch on an idle line must not start anything.
        b_wr = wr_total; b_done = done_n; b_err = err_n; hold0 = int'(hold);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        chk("glitch_no_event", (wr_total - b_wr) + (done_n - b_done) + (err_n - b_err), 0);
        chk("glitch_hold", 32'(hold), hold0);

        // Reset in the middle of the data phase, then a clean load.
        send_byte(8'h04, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h5A, 1'b1);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_hold", 32'(hold), 0);
        chk("mid_rst_wr_en", 32'(wr_en), 0);
        chk("mid_rst_wr_addr", 32'(wr_addr), 0);
        chk("mid_rst_wr_data", 32'(wr_data), 0);
        chk("mid_rst_prog_len", 32'(prog_len), 0);
        chk("mid_rst_done_err", 32'({done, err}), 0);
        chk("mid_rst_err_code", 32'(err_code), 0);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_pl = 0; exp_code = 0;
        repeat (20) @(negedge clk);
        fb.delete();
        fb.push_back(8'h02); fb.push_back(8'h40); fb.push_back(8'hC0); fb.push_back(8'h00);
        bad = -1;
        run_frame(0, 0, 2);

        // Maximum length program.
        fb.delete();
        fb.push_back(8'hFF);
        repeat (255) fb.push_back(8'h01);
        fb.push_back(8'h01);
        bad = -1;
        run_frame(0, 0, 255);

        // Randomized frames against the reference model.
        for (int t = 0; t < 25; t++) begin
            fb.delete();
            flen = $urandom_range(1, 8);
            fb.push_back(8'(flen));
            s = 8'd0;
            for (int j = 0; j < flen; j++) begin
                v = 8'($urandom);
                fb.push_back(v);
                s = s + v;
            end
            if ($urandom_range(0, 9) < 7) fb.push_back(8'h00 - s);
            else fb.push_back(8'($urandom));
            bad = -1;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                bad = $urandom_range(0, fb.size() - 1);
            end else if (r == 2) begin
                keep = $urandom_range(1, fb.size() - 1);
                while (fb.size() > keep) void'(fb.pop_back());
            end
            model(ek, ec, enw);
            run_frame(ek, ec, enw);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
